sockit_spi_rpi: RTL

//  Input repackager: converts serializer queue packets (SDW cycles x 4 IO lanes) into
//  CDW-bit command read words for the CPU side. Inverse of the output repackager.

---
 rtl/sockit_spi_pkg.sv | 67 ++++++
 rtl/sockit_spi_rpi_if.sv | 24 ++
 rtl/sockit_spi_rpi.sv | 101 ++++++++++
 3 files changed

// File: rtl/sockit_spi_pkg.sv
// Shared definitions for the SPI serializer repackagers: geometry, queue control
// field layout, IO mode encodings and the per-packet lane unpacker.
package sockit_spi_pkg;

  localparam int SDW = 8;
  localparam int SDL = $clog2(SDW);
  localparam int QCI = SDL + 3;
  localparam int QDW = 4 * SDW;
  localparam int CCI = 6;
  localparam int CDW = 32;
  localparam int NW  = $clog2(QDW) + 1;

  localparam int CTL_IOM = 0;
  localparam int CTL_LST = 2;
  localparam int CTL_LEN = 3;

  typedef enum logic [1:0] {
    IOM_3WR  = 2'd0,
    IOM_SPI  = 2'd1,
    IOM_DUAL = 2'd2,
    IOM_QUAD = 2'd3
  } iom_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } acc_state_t;

  typedef struct packed {
    logic [NW-1:0]  n;
    logic [QDW-1:0] bits;
  } unpack_t;

  // Gathers len+1 cycles of lane samples into a right-aligned field, earliest cycle on top.
  function automatic unpack_t unpack(input logic [QDW-1:0] dat, input iom_t iom,
                                     input logic [SDL-1:0] len);
    unpack_t r;
    logic [SDW-1:0] l0, l1, l2, l3;
    logic [NW-1:0] cyc;
    l0 = dat[0*SDW +: SDW];
    l1 = dat[1*SDW +: SDW];
    l2 = dat[2*SDW +: SDW];
    l3 = dat[3*SDW +: SDW];
    r.bits = '0;
    for (int i = 0; i < SDW; i++) begin
      if (i <= int'(len)) begin
        case (iom)
          IOM_QUAD: r.bits = {r.bits[QDW-5:0], l3[SDW-1], l2[SDW-1], l1[SDW-1], l0[SDW-1]};
          IOM_DUAL: r.bits = {r.bits[QDW-3:0], l1[SDW-1], l0[SDW-1]};
          default:  r.bits = {r.bits[QDW-2:0], l0[SDW-1]};
        endcase
      end
      l0 = l0 << 1;
      l1 = l1 << 1;
      l2 = l2 << 1;
      l3 = l3 << 1;
    end
    cyc = NW'(len) + NW'(1);
    case (iom)
      IOM_QUAD: r.n = cyc << 2;
      IOM_DUAL: r.n = cyc << 1;
      default:  r.n = cyc;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sockit_spi_rpi_if.sv
// Queue-side and command-side handshake bundle of the input repackager.
interface sockit_spi_rpi_if;
  import sockit_spi_pkg::*;

  logic           que_vld;
  logic [QCI-1:0] que_ctl;
  logic [QDW-1:0] que_dat;
  logic           que_rdy;
  logic           cmd_vld;
  logic [CCI-1:0] cmd_ctl;
  logic [CDW-1:0] cmd_dat;
  logic           cmd_rdy;

  modport slave (
    input  que_vld, que_ctl, que_dat, cmd_rdy,
    output que_rdy, cmd_vld, cmd_ctl, cmd_dat
  );

  modport master (
    output que_vld, que_ctl, que_dat, cmd_rdy,
    input  que_rdy, cmd_vld, cmd_ctl, cmd_dat
  );

endinterface

// File: rtl/sockit_spi_rpi.sv
// Input repackager: folds serializer queue packets into right-aligned command read words.
// state   | meaning
// ST_IDLE | no bits gathered for the current transfer (cnt = 0)
// ST_ACC  | partial word held in the accumulator, waiting for the lst packet
module sockit_spi_rpi
  import sockit_spi_pkg::*;
(
  input  logic clk,
  input  logic rst,
  sockit_spi_rpi_if.slave bus
);

  localparam int SW = NW + 1;

  acc_state_t     state_q, state_d;
  logic [CDW-1:0] acc_q, acc_d;
  logic [NW-1:0]  cnt_q, cnt_d;
  logic           ovf_q, ovf_d;
  logic           vld_q, vld_d;
  logic [CCI-1:0] ctl_q, ctl_d;
  logic [CDW-1:0] dat_q, dat_d;

  logic           que_rdy, que_trn, cmd_trn, lst;
  unpack_t        up;
  logic [CDW-1:0] acc_base, acc_new;
  logic [NW-1:0]  cnt_base, cnt_new;
  logic [SW-1:0]  cnt_sum;
  logic           ovf_base, over, ovf_new;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      vld_q   <= 1'b0;
      ctl_q   <= '0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      vld_q   <= vld_d;
      ctl_q   <= ctl_d;
      dat_q   <= dat_d;
    end
  end

  always_comb begin
    que_rdy = ~vld_q | bus.cmd_rdy;
    que_trn = bus.que_vld & que_rdy;
    cmd_trn = vld_q & bus.cmd_rdy;
    lst     = bus.que_ctl[CTL_LST];
    up      = unpack(bus.que_dat, iom_t'(bus.que_ctl[CTL_IOM +: 2]), bus.que_ctl[CTL_LEN +: SDL]);

    acc_base = (state_q == ST_ACC) ? acc_q : '0;
    cnt_base = (state_q == ST_ACC) ? cnt_q : '0;
    ovf_base = (state_q == ST_ACC) ? ovf_q : 1'b0;

    // A shift by the full word width yields zero, so n = CDW replaces the accumulator.
    acc_new = (acc_base << up.n) | CDW'(up.bits);
    cnt_sum = SW'(cnt_base) + SW'(up.n);
    over    = cnt_sum > SW'(CDW);
    cnt_new = over ? NW'(CDW) : cnt_sum[NW-1:0];
    ovf_new = ovf_base | over;

    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    vld_d   = vld_q;
    ctl_d   = ctl_q;
    dat_d   = dat_q;

    if (cmd_trn) vld_d = 1'b0;

    if (que_trn) begin
      if (lst) begin
        state_d = ST_IDLE;
        acc_d   = '0;
        cnt_d   = '0;
        ovf_d   = 1'b0;
        vld_d   = 1'b1;
        dat_d   = acc_new;
        ctl_d   = {ovf_new, (CCI-1)'(cnt_new - NW'(1))};
      end else begin
        state_d = ST_ACC;
        acc_d   = acc_new;
        cnt_d   = cnt_new;
        ovf_d   = ovf_new;
      end
    end
  end

  assign bus.que_rdy = que_rdy;
  assign bus.cmd_vld = vld_q;
  assign bus.cmd_ctl = ctl_q;
  assign bus.cmd_dat = dat_q;

endmodule
